// File: rtl/pipe_skid_reg.sv
// Two-entry skid register between pipeline stages with one-cycle latency, freeze and flush.
// Optional stall/flush statistics counters are built when PIPE_SKID_REG_STATS_EN is defined.
module pipe_skid_reg #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              push, pop;

    assign in_ready  = (state_q != StFull) && !freeze;
    assign out_valid = (state_q != StEmpty) && !freeze;
    assign out_data  = main_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        state_d = StOne;
                        main_d  = in_data;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push) begin
                        state_d = StFull;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = StEmpty;
                        main_d  = '0;
                    end
                end
                StFull: begin
                    // Skid drains into main; vacated entry reads as zero.
                    if (pop) begin
                        state_d = StOne;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_SKID_REG_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Both counters saturate at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomised checks for pipe_skid_reg; counter expectations follow
// whether PIPE_SKID_REG_STATS_EN is defined for the build.
module tb_pipe_skid_reg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 16;
`ifdef PIPE_SKID_REG_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    localparam logic [DATA_W-1:0] PA1 = 64'hAAAA_AAAA_AAAA_AAA1;
    localparam logic [DATA_W-1:0] P1  = 64'h1111_2222_3333_4444;
    localparam logic [DATA_W-1:0] P2  = 64'h5555_6666_7777_8888;
    localparam logic [DATA_W-1:0] PX  = 64'hDEAD_BEEF_CAFE_F00D;

    logic              clk = 1'b0;
    logic              rst, flush, freeze, in_valid, in_ready, out_valid, out_ready;
    logic [DATA_W-1:0] in_data, out_data;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    pipe_skid_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .freeze    (freeze),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; freeze = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; freeze = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin
            errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt);
        end
        freeze = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_freeze_in_ready got %b exp 0", in_ready); end
        freeze = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_latency();
        do_reset();
        in_valid = 1'b1; in_data = PA1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready_pre got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_out_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== PA1) begin errors++; $display("FAIL lat_out_data got %h exp %h", out_data, PA1); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready got %b exp 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== '0) begin
            errors++; $display("FAIL lat_drain got valid %b data %h exp 0/0", out_valid, out_data);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = P1;
        tick();
        in_data = P2;
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full got %b exp 0", in_ready); end
        repeat (3) tick();
        checks++; if (stall_cnt !== (StatsEn ? CNT_W'(4) : CNT_W'(0))) begin
            errors++; $display("FAIL bp_stall_cnt got %0d exp %0d", stall_cnt, StatsEn ? 4 : 0);
        end
        out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== P1) begin
            errors++; $display("FAIL bp_first got valid %b data %h exp 1/%h", out_valid, out_data, P1);
        end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== P2) begin
            errors++; $display("FAIL bp_second got valid %b data %h exp 1/%h", out_valid, out_data, P2);
        end
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== '0) begin
            errors++; $display("FAIL bp_empty got valid %b data %h exp 0/0", out_valid, out_data);
        end
        checks++; if (stall_cnt !== (StatsEn ? CNT_W'(4) : CNT_W'(0))) begin
            errors++; $display("FAIL bp_stall_hold got %0d exp %0d", stall_cnt, StatsEn ? 4 : 0);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = P1;
        tick();
        in_data = P2;
        tick();
        in_valid = 1'b0; freeze = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== P1) begin
                errors++;
                $display("FAIL frz_hold%0d got valid %b ready %b data %h exp 0/0/%h",
                         i, out_valid, in_ready, out_data, P1);
            end
            tick();
        end
        freeze = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== P1) begin
            errors++; $display("FAIL frz_first got valid %b data %h exp 1/%h", out_valid, out_data, P1);
        end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== P2) begin
            errors++; $display("FAIL frz_second got valid %b data %h exp 1/%h", out_valid, out_data, P2);
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL frz_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = P1;
        tick();
        in_data = P2;
        tick();
        flush = 1'b1; in_data = PX;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_full got valid %b data %h ready %b exp 0/0/1",
                               out_valid, out_data, in_ready);
        end
        checks++; if (flush_cnt !== (StatsEn ? CNT_W'(1) : CNT_W'(0))) begin
            errors++; $display("FAIL flush_cnt1 got %0d exp %0d", flush_cnt, StatsEn ? 1 : 0);
        end
        // Push accepted by the handshake in EMPTY must still be discarded by flush.
        flush = 1'b1; in_valid = 1'b1; in_data = PX; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== '0) begin
            errors++; $display("FAIL flush_push got valid %b data %h exp 0/0", out_valid, out_data);
        end
        checks++; if (flush_cnt !== (StatsEn ? CNT_W'(2) : CNT_W'(0))) begin
            errors++; $display("FAIL flush_cnt2 got %0d exp %0d", flush_cnt, StatsEn ? 2 : 0);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = P1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== P1) begin
            errors++; $display("FAIL arst_pre got valid %b data %h exp 1/%h", out_valid, out_data, P1);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== '0) begin
            errors++; $display("FAIL arst_now got valid %b data %h exp 0/0", out_valid, out_data);
        end
        checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin
            errors++; $display("FAIL arst_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt);
        end
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== '0) begin
            errors++; $display("FAIL arst_after got valid %b data %h exp 0/0", out_valid, out_data);
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] exp_q[$];
        logic [DATA_W-1:0] exp_front;
        logic              m_ready, m_valid;
        int                sent = 0;
        int                recv = 0;
        int                cycles = 0;
        do_reset();
        while (recv < 1000 && cycles < 20000) begin
            freeze    = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            #1;
            m_ready   = (exp_q.size() < 2) && !freeze;
            m_valid   = (exp_q.size() > 0) && !freeze;
            exp_front = (exp_q.size() > 0) ? exp_q[0] : '0;
            checks++; if (in_ready !== m_ready || out_valid !== m_valid) begin
                errors++; $display("FAIL rnd_hs cyc %0d got ready %b valid %b exp %b/%b",
                                   cycles, in_ready, out_valid, m_ready, m_valid);
            end
            checks++; if (out_data !== exp_front) begin
                errors++; $display("FAIL rnd_data cyc %0d got %h exp %h", cycles, out_data, exp_front);
            end
            if (m_valid && out_ready) begin
                void'(exp_q.pop_front());
                recv++;
            end
            if (in_valid && m_ready) begin
                exp_q.push_back(in_data);
                sent++;
            end
            tick();
            cycles++;
        end
        in_valid = 1'b0; freeze = 1'b0;
        checks++; if (recv != 1000) begin
            errors++; $display("FAIL rnd_count got %0d exp 1000 within budget", recv);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; freeze = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_latency();
        test_backpressure();
        test_freeze();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64, payload width (PC plus instruction).
REQ-002 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous pipeline flush.
REQ-006 SHALL have port freeze  input  1  hazard stall; no transfers while high.
REQ-007 SHALL have port in_valid  input  1  upstream payload valid.
REQ-008 SHALL have port in_ready  output  1  stage can accept.
REQ-009 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-010 SHALL have port out_valid  output  1  downstream payload valid.
REQ-011 SHALL have port out_ready  input  1  downstream can accept.
REQ-012 SHALL have port out_data  output  DATA_W  payload to next stage.
REQ-013 SHALL have port stall_cnt  output  CNT_W  backpressure cycle count.
REQ-014 SHALL have port flush_cnt  output  CNT_W  flush event count.

Function
REQ-015 SHALL hold a 2-entry storage: main register (drives out_data) and skid register, with occupancy state EMPTY, ONE or FULL.
REQ-016 SHALL drive in_ready = (state != FULL) and not freeze; out_valid = (state != EMPTY) and not freeze.
REQ-017 SHALL push when in_valid and in_ready; pop when out_valid and out_ready.
REQ-018 Transitions: EMPTY+push -> ONE (data into main); ONE+push only -> FULL (data into skid); ONE+pop only -> EMPTY; ONE+push+pop -> ONE (main loads in_data); FULL+pop -> ONE (skid moves to main).
REQ-019 SHALL deliver payloads strictly in push order, with no loss or duplication.
REQ-020 Latency SHALL be one cycle: data pushed into EMPTY appears on out_data with out_valid high in the next cycle.
REQ-021 SHALL sustain one transfer per cycle when out_ready is continuously high.
REQ-022 Freeze SHALL hold state, main, skid and out_data unchanged; handshake outputs go low in the same cycle.
REQ-023 Flush SHALL take priority over freeze, push and pop; the next state is EMPTY, main and skid are zeroed, and a same-cycle push is discarded.
REQ-024 Empty entries SHALL read as zero; out_data SHALL be 0 whenever state is EMPTY.

Reset
REQ-025 rst SHALL force state EMPTY, main=0, skid=0, stall_cnt=0 and flush_cnt=0 immediately, regardless of clk.
REQ-026 Reset outputs SHALL be out_valid=0, out_data=0, and in_ready=1 unless freeze is high.
REQ-027 rst asserted mid-transfer SHALL drop all held payloads; no partial payload is emitted after release.

Configuration
REQ-028 Macro PIPE_SKID_REG_STATS_EN SHALL control the statistics counters.
REQ-029 With the macro defined: stall_cnt SHALL increment each cycle that out_valid=1 and out_ready=0; flush_cnt SHALL increment each cycle with flush=1; both saturate at all-ones.
REQ-030 With the macro undefined: stall_cnt and flush_cnt SHALL remain present and be tied to 0, with no counter logic.

Verification
REQ-031 After rst, push 0xA..A1 with out_ready=1 -> out_valid=1 and out_data=0xA..A1 exactly one cycle later; in_ready stays 1.
REQ-032 With out_ready=0, push P1 then P2 -> in_ready=0 after the 2nd push; raise out_ready -> P1 then P2 on consecutive cycles; stall_cnt (macro on) equals the cycles held.
REQ-033 In FULL, assert freeze for 3 cycles with out_ready=1 -> no pops, out_valid=0, data unchanged; after freeze drops, P1 and P2 delivered in order.
REQ-034 In FULL, assert flush together with in_valid=1 -> next cycle EMPTY, out_data=0, pushed payload lost, flush_cnt=1 (macro on) or 0 (macro off).
REQ-035 In ONE state, assert rst asynchronously between clock edges -> out_valid=0 and out_data=0 immediately, both counters read 0.
REQ-036 Random valid/ready/freeze stream of 1000 payloads with no flush -> output sequence equals input sequence exactly.
